// File: rtl/reg_file_param.sv
// Parameterised multi-port register file with a power-on clear sequencer.
// After reset an INIT phase writes zero to every entry, one per clock, then
// the file enters RUN and accepts writes from the single write port.
//
// Parameters:
//   DATA_W   entry width in bits
//   ADDR_W   address width, DEPTH = 2**ADDR_W entries
//   NUM_RD   number of asynchronous read ports (1..4)
//   ZERO_REG 1 = entry 0 is hardwired to zero
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   we        write enable
//   waddr     write address
//   wdata     write data
//   raddr     packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata     packed read data, port k at [k*DATA_W +: DATA_W]
//   init_busy high while the clear sequencer runs (and during reset)
//   wr_drop   one-cycle pulse after a write discarded during INIT
//
// Optional feature: define REGFILE_BYPASS_EN to forward wdata to a read
// port reading the address being written in the same cycle.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     init_busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Last entry index (DEPTH-1) is the all-ones address.
    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] init_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic in_init;
    logic in_run;
    logic wr_zero;
    logic wr_ok;

    assign in_init = (state == ST_INIT);
    assign in_run  = (state == ST_RUN);

    // Writes to the hardwired entry are silently ignored, not dropped.
    assign wr_zero = (ZERO_REG != 0) && (waddr == '0);
    assign wr_ok   = in_run && we && !wr_zero;

    // Reset is ORed in so the outputs are safe before the first edge.
    assign init_busy = reset | in_init;

    // Control path: FSM, clear pointer, drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            init_ptr <= '0;
            wr_drop  <= 1'b0;
        end else begin
            wr_drop <= in_init && we;
            if (in_init) begin
                init_ptr <= init_ptr + 1'b1;
                if (init_ptr == LAST_PTR) begin
                    state <= ST_RUN;
                end
            end
        end
    end

    // Storage: cleared by the sequencer, no reset on the array itself.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (in_init) begin
                mem[init_ptr] <= '0;
            end else if (wr_ok) begin
                mem[waddr] <= wdata;
            end
        end
    end

    logic [ADDR_W-1:0] ra [NUM_RD];
    logic [DATA_W-1:0] rd [NUM_RD];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign ra[k] = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd[k] = mem[ra[k]];
            if (init_busy) begin
                rd[k] = '0;
            end else if ((ZERO_REG != 0) && (ra[k] == '0)) begin
                rd[k] = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (wr_ok && (ra[k] == waddr)) begin
                rd[k] = wdata;
`endif
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd[k];
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param (defaults, 2 read ports).
// Covers clear sequencing, RUN writes, zero register, drops and restarts.
module tb_reg_file_param;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        init_busy;
    logic        wr_drop;

    int checks;
    int errors;
    int n;

    reg_file_param dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .init_busy (init_busy),
        .wr_drop   (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All helpers start and end just after a falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Counts edges until init_busy falls, bounded.
    task automatic wait_init(output int cnt);
        cnt = 0;
        while (init_busy && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr  = '0;

        @(negedge clk);
        rd(5'd7, 5'd31);
        check("busy_in_reset", {31'd0, init_busy}, 32'd1);
        check("rd0_in_reset", rdata[31:0], 32'd0);
        check("rd1_in_reset", rdata[63:32], 32'd0);

        do_reset();
        check("busy_after_rel", {31'd0, init_busy}, 32'd1);
        check("drop_after_rst", {31'd0, wr_drop}, 32'd0);
        wait_init(n);
        check("init_edges", n, 32'd32);
        check("busy_run", {31'd0, init_busy}, 32'd0);

        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            check("clr_p0", rdata[31:0], 32'd0);
            check("clr_p1", rdata[63:32], 32'd0);
        end

        wr(5'd7, 32'hDEADBEEF);
        rd(5'd7, 5'd7);
        check("wr7_p0", rdata[31:0], 32'hDEADBEEF);
        check("wr7_p1", rdata[63:32], 32'hDEADBEEF);
        check("wr7_drop", {31'd0, wr_drop}, 32'd0);

        wr(5'd0, 32'h12345678);
        rd(5'd0, 5'd0);
        check("zr_p0", rdata[31:0], 32'd0);
        check("zr_p1", rdata[63:32], 32'd0);
        check("zr_drop", {31'd0, wr_drop}, 32'd0);

        wr(5'd31, 32'h80000001);
        rd(5'd7, 5'd31);
        check("wr31_p0", rdata[31:0], 32'hDEADBEEF);
        check("wr31_p1", rdata[63:32], 32'h80000001);

        wr(5'd9, 32'hAAAA5555);
        rd(5'd9, 5'd10);
        check("wr9_old", rdata[31:0], 32'hAAAA5555);
        we    = 1'b1;
        waddr = 5'd9;
        wdata = 32'h0000FFFF;
        rd(5'd9, 5'd10);
`ifdef REGFILE_BYPASS_EN
        check("byp9_p0", rdata[31:0], 32'h0000FFFF);
`else
        check("byp9_p0", rdata[31:0], 32'hAAAA5555);
`endif
        check("byp9_p1", rdata[63:32], 32'd0);
        step();
        we = 1'b0;
        rd(5'd9, 5'd9);
        check("wr9_new", rdata[31:0], 32'h0000FFFF);

        we    = 1'b1;
        waddr = 5'd0;
        wdata = 32'hFFFFFFFF;
        rd(5'd0, 5'd9);
        check("byp0_p0", rdata[31:0], 32'd0);
        check("byp0_p1", rdata[63:32], 32'h0000FFFF);
        step();
        we = 1'b0;

        do_reset();
        for (int e = 1; e <= 4; e++) step();
        wr(5'd3, 32'hCAFEBABE);
        rd(5'd7, 5'd3);
        check("drop_hi", {31'd0, wr_drop}, 32'd1);
        check("drop_busy", {31'd0, init_busy}, 32'd1);
        check("init_rd7", rdata[31:0], 32'd0);
        step();
        check("drop_lo", {31'd0, wr_drop}, 32'd0);
        wait_init(n);
        check("init2_edges", n + 6, 32'd32);
        rd(5'd3, 5'd7);
        check("drop3_rd", rdata[31:0], 32'd0);
        check("recl7_rd", rdata[63:32], 32'd0);
        check("run_drop", {31'd0, wr_drop}, 32'd0);

        wr(5'd5, 32'h5A5A5A5A);
        rd(5'd5, 5'd31);
        check("wr5_rd", rdata[31:0], 32'h5A5A5A5A);
        do_reset();
        for (int e = 1; e <= 10; e++) step();
        reset = 1'b1;
        we    = 1'b1;
        waddr = 5'd20;
        wdata = 32'h0BADF00D;
        rd(5'd5, 5'd20);
        check("mid_busy", {31'd0, init_busy}, 32'd1);
        check("mid_rd", rdata[31:0], 32'd0);
        step();
        reset = 1'b0;
        we    = 1'b0;
        check("mid_drop", {31'd0, wr_drop}, 32'd0);
        wait_init(n);
        check("restart_edges", n, 32'd32);
        rd(5'd5, 5'd20);
        check("rst5_rd", rdata[31:0], 32'd0);
        check("rst20_rd", rdata[63:32], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, number of asynchronous read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 is hardwired to zero.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port waddr  input  ADDR_W  write address.
REQ-009 SHALL have port wdata  input  DATA_W  write data.
REQ-010 SHALL have port raddr  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rdata  output  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port init_busy  output  1  high while the clear sequencer runs.
REQ-013 SHALL have port wr_drop  output  1  one-cycle pulse when a write is discarded.

Function
REQ-014 SHALL implement a two-state FSM: INIT and RUN.
REQ-015 In INIT, each rising edge SHALL write zero to entry init_ptr and increment init_ptr by 1.
REQ-016 The edge that clears entry DEPTH-1 SHALL move the FSM to RUN; init_ptr SHALL NOT wrap within INIT.
REQ-017 init_busy SHALL be 1 in INIT and 0 in RUN; init takes exactly DEPTH edges after reset deasserts.
REQ-018 In RUN, a rising edge with we=1 SHALL write wdata to entry waddr.
REQ-019 With ZERO_REG=1, writes to waddr 0 SHALL be ignored and SHALL NOT pulse wr_drop.
REQ-020 A we=1 edge in INIT SHALL discard the write and assert wr_drop for the following cycle.
REQ-021 wr_drop SHALL be registered, high for exactly one cycle per discarded write, else 0.
REQ-022 Each read port SHALL be combinational from raddr and stored contents.
REQ-023 While init_busy=1, every rdata port SHALL read 0.
REQ-024 With ZERO_REG=1, raddr 0 SHALL read 0 in all states.
REQ-025 Simultaneous reads of the same address on multiple ports SHALL all return the same value.
REQ-026 Entry width SHALL be exactly DATA_W; no truncation or sign extension.

Reset
REQ-027 reset=1 at a rising edge SHALL force the FSM to INIT, init_ptr to 0 and wr_drop to 0.
REQ-028 Reset asserted mid-INIT SHALL restart clearing from entry 0.
REQ-029 Reset asserted in RUN SHALL re-enter INIT; stored contents are undefined until re-cleared.
REQ-030 While reset=1, init_busy SHALL be 1, rdata SHALL read 0, and no entry write from we SHALL occur.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-032 With REGFILE_BYPASS_EN defined, in RUN with we=1 and raddr==waddr (excluding hardwired entry 0), that port SHALL return wdata combinationally in the same cycle.
REQ-033 Without REGFILE_BYPASS_EN, a read of the address being written SHALL return the old value until the next rising edge.

Verification
REQ-034 Reset 1 cycle, then release, DATA_W=32 ADDR_W=5 -> init_busy high for exactly 32 edges, then low; all 32 entries read 0x00000000.
REQ-035 RUN, write 0xDEADBEEF to addr 7, next cycle raddr port0=7, port1=7 -> both ports read 0xDEADBEEF.
REQ-036 RUN, write 0x12345678 to addr 0 with ZERO_REG=1 -> addr 0 reads 0; wr_drop stays 0.
REQ-037 we=1 addr 3 data 0xCAFEBABE on INIT edge 5 -> wr_drop high for 1 cycle; after INIT, addr 3 reads 0.
REQ-038 Reset asserted after INIT edge 10 -> init restarts at entry 0; init_busy low only after 32 further edges.
REQ-039 RUN, we=1 addr 9 data 0x0000FFFF, raddr=9 same cycle -> 0x0000FFFF with REGFILE_BYPASS_EN defined, previous value without it.
